// File: rtl/dqsw_delay_trainer.sv
// dqsw_delay_trainer
// Multi-lane DQS write-window training controller. For each lane in turn
// (lane 0 first) the delay line is returned to its origin and then stepped
// through every tap. At each tap the eye-monitor flags are observed for a
// fixed window. The longest contiguous run of passing taps is tracked, and
// the lane is finally parked at the centre of that run.
//
// Ports
//   FAB_CLK                  single rising-edge clock
//   ARST_N                   asynchronous active-low reset
//   start                    one-cycle training request, accepted in IDLE only
//   busy                     training in progress
//   done                     level, all lanes finished (cleared by next start)
//   error                    OR of lane_fail, valid while done=1
//   lane_fail[i]             lane i found no window of at least MIN_WINDOW taps
//   lane_tap[i*TAP_BITS+:]   final (centre) tap of lane i
//   DELAY_LINE_LOAD[i]       pulse, return lane i delay to tap 0
//   DELAY_LINE_MOVE[i]       pulse, one tap step on lane i
//   DELAY_LINE_DIRECTION[i]  1 = increment, high with every MOVE
//   EYE_MONITOR_CLEAR_FLAGS  pulse, clear sticky eye flags of lane i
//   DELAY_LINE_OUT_OF_RANGE  delay line of lane i at its limit
//   EYE_MONITOR_EARLY/LATE   eye flags of lane i
module dqsw_delay_trainer #(
  parameter int NUM_LANES     = 2,
  parameter int TAP_BITS      = 7,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                          FAB_CLK,
  input  logic                          ARST_N,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [NUM_LANES-1:0]          lane_fail,
  output logic [NUM_LANES*TAP_BITS-1:0] lane_tap,
  output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]          EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE,
  input  logic [NUM_LANES-1:0]          EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]          EYE_MONITOR_LATE
);

  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  // Run lengths reach 2^TAP_BITS when every tap passes, hence one extra bit.
  localparam int LEN_W   = TAP_BITS + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TAP_BITS-1:0] MAX_TAP   = {TAP_BITS{1'b1}};
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_CLEAR  = 4'd2,
    ST_SETTLE = 4'd3,
    ST_SAMPLE = 4'd4,
    ST_EVAL   = 4'd5,
    ST_STEP   = 4'd6,
    ST_CLOAD  = 4'd7,
    ST_CMOVE  = 4'd8,
    ST_NEXT   = 4'd9,
    ST_DONE   = 4'd10
  } state_t;

  // One-hot select of a lane; used to gate every per-lane pulse and flag.
  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_W-1:0] idx);
    logic [NUM_LANES-1:0] v;
    for (int i = 0; i < NUM_LANES; i++) begin
      v[i] = (idx == LANE_W'(i));
    end
    return v;
  endfunction

  state_t                        state_r;
  logic [LANE_W-1:0]             lane_r;
  logic [TAP_BITS-1:0]           tap_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          tap_fail_r;
  logic [TAP_BITS-1:0]           run_start_r;
  logic [LEN_W-1:0]              run_len_r;
  logic [TAP_BITS-1:0]           best_start_r;
  logic [LEN_W-1:0]              best_len_r;
  logic [TAP_BITS-1:0]           centre_r;
  logic [TAP_BITS-1:0]           rem_r;
  logic                          move_phase_r;
  logic [NUM_LANES-1:0]          eye_early_r;
  logic [NUM_LANES-1:0]          eye_late_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          error_r;
  logic [NUM_LANES-1:0]          lane_fail_r;
  logic [NUM_LANES*TAP_BITS-1:0] lane_tap_r;
  logic [NUM_LANES-1:0]          load_r;
  logic [NUM_LANES-1:0]          move_r;
  logic [NUM_LANES-1:0]          dir_r;
  logic [NUM_LANES-1:0]          clear_r;

  logic [NUM_LANES-1:0]          lane_sel_s;
  logic                          flag_s;
  logic                          oor_s;
  logic                          tap_pass_s;
  logic                          sweep_end_s;
  logic [LEN_W-1:0]              run_len_n_s;
  logic [TAP_BITS-1:0]           run_start_n_s;
  logic [LEN_W-1:0]              cand_len_s;
  logic [TAP_BITS-1:0]           cand_start_s;
  logic [LEN_W-1:0]              best_len_n_s;
  logic [TAP_BITS-1:0]           best_start_n_s;
  logic [TAP_BITS-1:0]           half_s;
  logic                          win_fail_s;
  logic [TAP_BITS-1:0]           centre_n_s;

  assign busy                    = busy_r;
  assign done                    = done_r;
  assign error                   = error_r;
  assign lane_fail               = lane_fail_r;
  assign lane_tap                = lane_tap_r;
  assign DELAY_LINE_LOAD         = load_r;
  assign DELAY_LINE_MOVE         = move_r;
  assign DELAY_LINE_DIRECTION    = dir_r;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_r;

  // Active-lane views of the eye flags and the range limit.
  always_comb begin
    lane_sel_s  = lane_bit(lane_r);
    flag_s      = |((eye_early_r | eye_late_r) & lane_sel_s);
    oor_s       = |(DELAY_LINE_OUT_OF_RANGE & lane_sel_s);
    tap_pass_s  = !tap_fail_r && !oor_s;
    sweep_end_s = oor_s || (tap_r == MAX_TAP);
  end

  // Run/best window update for the tap being evaluated, plus the centre the
  // lane would be parked at if the sweep ends here.
  always_comb begin
    run_len_n_s    = '0;
    run_start_n_s  = run_start_r;
    cand_len_s     = run_len_r;
    cand_start_s   = run_start_r;
    best_len_n_s   = best_len_r;
    best_start_n_s = best_start_r;
    if (tap_pass_s) begin
      run_len_n_s   = run_len_r + LEN_W'(1);
      run_start_n_s = (run_len_r == '0) ? tap_r : run_start_r;
      cand_len_s    = run_len_n_s;
      cand_start_s  = run_start_n_s;
    end else begin
      run_len_n_s   = '0;
      run_start_n_s = run_start_r;
    end
    // A run competes only once it is closed (failing tap) or the sweep ends
    // with it still open; strictly-longer keeps the earliest of equal windows.
    if ((!tap_pass_s || sweep_end_s) && (cand_len_s > best_len_r)) begin
      best_len_n_s   = cand_len_s;
      best_start_n_s = cand_start_s;
    end else begin
      best_len_n_s   = best_len_r;
      best_start_n_s = best_start_r;
    end
    half_s = TAP_BITS'((best_len_n_s - LEN_W'(1)) >> 1);
    if (best_len_n_s < LEN_W'(MIN_WINDOW)) begin
      win_fail_s = 1'b1;
      centre_n_s = '0;
    end else begin
      win_fail_s = 1'b0;
      centre_n_s = best_start_n_s + half_s;
    end
  end

  // Eye flags registered once before sampling.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      eye_early_r <= '0;
      eye_late_r  <= '0;
    end else begin
      eye_early_r <= EYE_MONITOR_EARLY;
      eye_late_r  <= EYE_MONITOR_LATE;
    end
  end

  // Training FSM. Pulse outputs are set on entry to the state that owns
  // them so they are visible exactly during that state.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r      <= ST_IDLE;
      lane_r       <= '0;
      tap_r        <= '0;
      cnt_r        <= '0;
      tap_fail_r   <= 1'b0;
      run_start_r  <= '0;
      run_len_r    <= '0;
      best_start_r <= '0;
      best_len_r   <= '0;
      centre_r     <= '0;
      rem_r        <= '0;
      move_phase_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      lane_fail_r  <= '0;
      lane_tap_r   <= '0;
      load_r       <= '0;
      move_r       <= '0;
      dir_r        <= '0;
      clear_r      <= '0;
    end else begin
      load_r  <= '0;
      move_r  <= '0;
      dir_r   <= '0;
      clear_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            lane_fail_r <= '0;
            lane_tap_r  <= '0;
            lane_r      <= '0;
            load_r      <= lane_bit(LANE_W'(0));
            state_r     <= ST_LOAD;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          tap_r        <= '0;
          run_len_r    <= '0;
          run_start_r  <= '0;
          best_len_r   <= '0;
          best_start_r <= '0;
          clear_r      <= lane_sel_s;
          state_r      <= ST_CLEAR;
        end
        ST_CLEAR: begin
          cnt_r   <= '0;
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_r      <= '0;
            tap_fail_r <= 1'b0;
            state_r    <= ST_SAMPLE;
          end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          tap_fail_r <= tap_fail_r | flag_s;
          if (cnt_r == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_r <= ST_EVAL;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          run_len_r    <= run_len_n_s;
          run_start_r  <= run_start_n_s;
          best_len_r   <= best_len_n_s;
          best_start_r <= best_start_n_s;
          if (sweep_end_s) begin
            centre_r              <= centre_n_s;
            lane_fail_r[lane_r]   <= win_fail_s;
            load_r                <= lane_sel_s;
            state_r               <= ST_CLOAD;
          end else begin
            move_r                <= lane_sel_s;
            dir_r                 <= lane_sel_s;
            state_r               <= ST_STEP;
          end
        end
        ST_STEP: begin
          tap_r   <= tap_r + TAP_BITS'(1);
          clear_r <= lane_sel_s;
          state_r <= ST_CLEAR;
        end
        ST_CLOAD: begin
          if (centre_r == '0) begin
            lane_tap_r[int'(lane_r) * TAP_BITS +: TAP_BITS] <= centre_r;
            state_r      <= ST_NEXT;
          end else begin
            move_r       <= lane_sel_s;
            dir_r        <= lane_sel_s;
            rem_r        <= centre_r - TAP_BITS'(1);
            move_phase_r <= 1'b1;
            state_r      <= ST_CMOVE;
          end
        end
        ST_CMOVE: begin
          // Alternate MOVE and gap cycles so no two MOVE pulses touch.
          if (move_phase_r) begin
            move_phase_r <= 1'b0;
          end else if (rem_r == '0) begin
            lane_tap_r[int'(lane_r) * TAP_BITS +: TAP_BITS] <= centre_r;
            state_r      <= ST_NEXT;
          end else begin
            move_r       <= lane_sel_s;
            dir_r        <= lane_sel_s;
            rem_r        <= rem_r - TAP_BITS'(1);
            move_phase_r <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (lane_r == LAST_LANE) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            error_r <= |lane_fail_r;
            state_r <= ST_DONE;
          end else begin
            lane_r  <= lane_r + LANE_W'(1);
            load_r  <= lane_bit(lane_r + LANE_W'(1));
            state_r <= ST_LOAD;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// tb_dqsw_delay_trainer
// Directed bench for dqsw_delay_trainer (2 lanes, 4-bit taps, settle 2,
// sample 4, minimum window 3). A small IOD model follows LOAD/MOVE per lane
// and drives the eye flags from a per-lane pass mask indexed by its tap.
module tb_dqsw_delay_trainer;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N;
  logic       start;
  logic       busy, done, error;
  logic [1:0] lane_fail;
  logic [7:0] lane_tap;
  logic [1:0] dl_load, dl_move, dl_dir, eye_clr;
  logic [1:0] oor, early, late;

  logic [15:0] mask0, mask1;
  logic        oor_en0;
  logic [3:0]  oor_tap0;
  logic        inj_en;

  logic [3:0] mtap [2] = '{4'd0, 4'd0};
  int         mv_cnt [2] = '{0, 0};
  int         ld_cnt [2] = '{0, 0};
  int         pulse_cnt = 0;
  int         viol = 0;
  int         since_clr = 100;
  logic [1:0] prev_move = 2'b00;
  logic       lane1_seen = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  dqsw_delay_trainer #(
    .NUM_LANES(2), .TAP_BITS(4), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .MIN_WINDOW(3)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .start                   (start),
    .busy                    (busy),
    .done                    (done),
    .error                   (error),
    .lane_fail               (lane_fail),
    .lane_tap                (lane_tap),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS (eye_clr),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // IOD model: flags follow the pass mask at the modelled tap.
  assign early = {~mask1[mtap[1]], ~mask0[mtap[0]]};
  assign late  = {1'b0, inj_en && (mtap[0] == 4'd8) && (since_clr == 5)};
  assign oor   = {1'b0, oor_en0 && (mtap[0] >= oor_tap0)};

  function automatic int bad_lane(input logic ld, input logic mv, input logic dr, input logic pmv);
    return int'(mv && ld) + int'(mv && !dr) + int'(mv && pmv);
  endfunction

  // Tap tracking, pulse counting and protocol monitoring.
  always @(negedge FAB_CLK) begin
    for (int l = 0; l < 2; l++) begin
      if (dl_load[l]) begin
        mtap[l]   <= 4'd0;
        ld_cnt[l] <= ld_cnt[l] + 1;
      end else if (dl_move[l] && dl_dir[l] && mtap[l] != 4'd15) begin
        mtap[l]   <= mtap[l] + 4'd1;
      end
      if (dl_move[l]) mv_cnt[l] <= mv_cnt[l] + 1;
    end
    viol <= viol + bad_lane(dl_load[0], dl_move[0], dl_dir[0], prev_move[0])
                 + bad_lane(dl_load[1], dl_move[1], dl_dir[1], prev_move[1])
                 + int'(lane1_seen && (dl_move[0] || eye_clr[0]))
                 + int'(!lane1_seen && (dl_move[1] || eye_clr[1]));
    prev_move <= dl_move;
    if (dl_load[1]) lane1_seen <= 1'b1;
    else if (dl_load[0]) lane1_seen <= 1'b0;
    pulse_cnt <= pulse_cnt + $countones({dl_load, dl_move, dl_dir, eye_clr});
    since_clr <= eye_clr[0] ? 0 : since_clr + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_train(input string name, input logic [15:0] m0, input logic [15:0] m1,
                           input logic oen0, input logic [3:0] otap0, input logic inj,
                           input logic repulse, input logic [1:0] e_fail, input logic [7:0] e_tap,
                           input int e_cyc, input int e_mv0, input int e_mv1);
    int   b_mv0, b_mv1, b_ld0, b_ld1, b_viol, cyc;
    logic seen;
    mask0 = m0; mask1 = m1; oor_en0 = oen0; oor_tap0 = otap0; inj_en = inj;
    @(negedge FAB_CLK);
    b_mv0 = mv_cnt[0]; b_mv1 = mv_cnt[1]; b_ld0 = ld_cnt[0]; b_ld1 = ld_cnt[1]; b_viol = viol;
    start = 1'b1;
    @(negedge FAB_CLK);
    start = 1'b0;
    check_eq({name, ".busy_after_start"}, 32'(busy), 32'd1);
    check_eq({name, ".load_after_start"}, 32'(dl_load), 32'd1);
    check_eq({name, ".done_cleared"}, 32'(done), 32'd0);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 3000 && !seen; i++) begin
      @(negedge FAB_CLK);
      start = (repulse && i == 50) ? 1'b1 : 1'b0;
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    start = 1'b0;
    check_eq({name, ".done_seen"}, 32'(seen), 32'd1);
    check_eq({name, ".cycles"}, 32'(cyc), 32'(e_cyc));
    check_eq({name, ".busy_at_done"}, 32'(busy), 32'd0);
    @(negedge FAB_CLK);
    check_eq({name, ".done_held"}, 32'(done), 32'd1);
    check_eq({name, ".lane_fail"}, 32'(lane_fail), 32'(e_fail));
    check_eq({name, ".error"}, 32'(error), 32'(|e_fail));
    check_eq({name, ".lane_tap"}, 32'(lane_tap), 32'(e_tap));
    check_eq({name, ".iod_tap0"}, 32'(mtap[0]), 32'(e_tap[3:0]));
    check_eq({name, ".iod_tap1"}, 32'(mtap[1]), 32'(e_tap[7:4]));
    check_eq({name, ".moves0"}, 32'(mv_cnt[0] - b_mv0), 32'(e_mv0));
    check_eq({name, ".moves1"}, 32'(mv_cnt[1] - b_mv1), 32'(e_mv1));
    check_eq({name, ".loads0"}, 32'(ld_cnt[0] - b_ld0), 32'd2);
    check_eq({name, ".loads1"}, 32'(ld_cnt[1] - b_ld1), 32'd2);
    check_eq({name, ".protocol"}, 32'(viol - b_viol), 32'd0);
  endtask

  initial begin
    int b_pulse;
    ARST_N = 1'b0; start = 1'b0;
    mask0 = 16'hFFFF; mask1 = 16'hFFFF; oor_en0 = 1'b0; oor_tap0 = 4'd0; inj_en = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check_eq("reset.status", 32'({busy, done, error}), 32'd0);
    check_eq("reset.lane_fail", 32'(lane_fail), 32'd0);
    check_eq("reset.lane_tap", 32'(lane_tap), 32'd0);
    check_eq("reset.pulses", 32'({dl_load, dl_move, dl_dir, eye_clr}), 32'd0);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);

    //        name   lane0 mask  lane1 mask  oor  otap  inj   rep   fail    tap    cyc mv0 mv1
    run_train("basic",  16'h07E0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'h77, 320, 22, 22);
    run_train("best",   16'h1F1C, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'h7A, 326, 25, 22);
    run_train("tie",    16'h0E0E, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'h72, 310, 17, 22);
    run_train("nopass", 16'h07E0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 8'h07, 306, 22, 15);
    run_train("short",  16'h07E0, 16'h00C0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 8'h07, 306, 22, 15);
    run_train("oor",    16'h0078, 16'hFFFF, 1'b1, 4'd6, 1'b0, 1'b0, 2'b00, 8'h74, 233, 10, 22);
    run_train("late",   16'h07E0, 16'hFFFF, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00, 8'h76, 318, 21, 22);
    run_train("repulse",16'h07E0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 8'h77, 320, 22, 22);

    // Abort in the middle of the lane 1 sweep.
    mask0 = 16'h07E0; mask1 = 16'hFFFF; oor_en0 = 1'b0; inj_en = 1'b0;
    @(negedge FAB_CLK);
    start = 1'b1;
    @(negedge FAB_CLK);
    start = 1'b0;
    repeat (200) @(negedge FAB_CLK);
    check_eq("abort.busy_before", 32'(busy), 32'd1);
    ARST_N = 1'b0;
    #1;
    check_eq("abort.status", 32'({busy, done, error}), 32'd0);
    check_eq("abort.lane_fail", 32'(lane_fail), 32'd0);
    check_eq("abort.lane_tap", 32'(lane_tap), 32'd0);
    check_eq("abort.pulses", 32'({dl_load, dl_move, dl_dir, eye_clr}), 32'd0);
    b_pulse = pulse_cnt;
    repeat (4) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    check_eq("abort.quiet", 32'(pulse_cnt - b_pulse), 32'd0);
    check_eq("abort.idle", 32'(busy), 32'd0);

    run_train("restart",16'h07E0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'h77, 320, 22, 22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dqsw_delay_trainer.md
# dqsw_delay_trainer

Multi-lane DQS write-window training controller. Drives the dynamic delay-line controls and reads the eye-monitor flags of NUM_LANES training IODs, sweeping each lane's delay from the loaded origin through every tap and locating the longest contiguous passing window. It then leaves each lane's delay at the window centre. The block sits between the DDR PHY training sequencer and the per-lane DQSW training IOD instances, and generalises single-lane manual delay stepping to an autonomous, parametrised sweep.

## Interface
- NUM_LANES, 2: number of IOD lanes trained (1..8).
- TAP_BITS, 7: tap counter width; last tap MAX_TAP = 2^TAP_BITS-1.
- SETTLE_CYCLES, 4: idle cycles after clear before sampling (>=1).
- SAMPLE_CYCLES, 16: cycles the eye flags are observed per tap (>=1).
- MIN_WINDOW, 4: minimum passing run length for a lane to succeed (>=1).

- FAB_CLK  in  1  single clock; all logic is rising-edge.
- ARST_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  level; set when all lanes finish; cleared by the next accepted start.
- error  out  1  OR of lane_fail, valid when done=1.
- lane_fail  out  NUM_LANES  bit i = lane i found no window >= MIN_WINDOW.
- lane_tap  out  NUM_LANES*TAP_BITS  final tap of lane i at [i*TAP_BITS +: TAP_BITS].
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle pulse; returns lane delay to origin (tap 0).
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle pulse; one tap step.
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment; held 1 whenever MOVE is issued.
- EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle pulse clearing sticky flags.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  delay line at its limit.
- EYE_MONITOR_EARLY  in  NUM_LANES  early flag.
- EYE_MONITOR_LATE  in  NUM_LANES  late flag.

## Operation
- Lanes are trained sequentially, lane 0 first. Only the active lane's output bits ever pulse; all others stay 0.
- FSM states: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CLOAD, CMOVE, NEXT, DONE.
- IDLE -> LOAD on start. Start resets lane index, lane_fail, lane_tap and done.
- LOAD: pulse LOAD, tap=0, clear run/best trackers -> CLEAR.
- CLEAR: pulse CLEAR_FLAGS -> SETTLE. SETTLE counts SETTLE_CYCLES -> SAMPLE.
- SAMPLE: for SAMPLE_CYCLES cycles, any EARLY or LATE high on the active lane marks the tap failing -> EVAL.
- EVAL:
  - If OUT_OF_RANGE is high, the tap counts as failing and the sweep ends.
  - Otherwise, a passing tap extends the run (run_start=tap when run_len=0). A failing tap closes the run.
  - A closed run, or an open run at sweep end, replaces best only if strictly longer; ties keep the earliest window.
  - The sweep ends at tap==MAX_TAP or on OUT_OF_RANGE; otherwise -> STEP.
- STEP: pulse MOVE with DIRECTION=1, tap+1 -> CLEAR.
- Sweep end: centre = best_start + ((best_len-1)>>1) (TAP_BITS-wide, no overflow possible).
  - If best_len < MIN_WINDOW: lane_fail[i]=1, centre=0.
  - Then -> CLOAD.
- CLOAD: pulse LOAD -> CMOVE. CMOVE issues centre MOVE pulses on alternate cycles (MOVE, gap, ...); zero pulses if centre=0. Then write lane_tap[i]=centre -> NEXT.
- NEXT: last lane -> DONE, else lane+1 -> LOAD.
- DONE: done=1, busy=0 -> IDLE in the same cycle; done stays high in IDLE.
- Start while busy is ignored. Flags and OUT_OF_RANGE on inactive lanes are ignored.

## Timing
- Reset values: every output 0; FSM in IDLE.
- ARST_N low mid-training aborts immediately. No delay-line pulses are issued until the next start.
- start seen at edge n -> busy=1 and LOAD pulse at cycle n+1.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + SAMPLE_CYCLES + 1 (EVAL) + 1 (STEP).
- Centring cost: 1 + 2*centre cycles.
- MOVE and LOAD are never asserted in the same cycle. No two MOVE pulses are ever adjacent.
- The EYE inputs are registered once before use, so the sampling window covers the flags from SAMPLE entry-1 to SAMPLE exit-1.

## Test plan
Common setup: NUM_LANES=2, TAP_BITS=4, SETTLE=2, SAMPLE=4, MIN_WINDOW=3. A bench IOD model tracks taps from LOAD/MOVE.
- Lane 0 passes taps 5..10, lane 1 passes 0..15 -> lane_tap0=7, lane_tap1=7; 7 MOVE pulses per lane after CLOAD; error=0.
- Lane 0 windows 2..4 and 8..12 -> lane_tap0=10. Equal windows 1..3 and 9..11 -> lane_tap0=2 (earliest kept).
- Lane 1 never passes, or passes only 6..7 -> lane_fail=2'b10, error=1, lane_tap1=0, no MOVE on lane 1 after CLOAD.
- Lane 0 passes 3..6 and OUT_OF_RANGE asserts at tap 6 -> sweep stops at tap 6, window 3..5, lane_tap0=4.
- A single LATE pulse in the 3rd SAMPLE cycle at tap 8 inside window 5..10 splits it -> best window 5..7, lane_tap0=6.
- Start re-pulsed while busy -> ignored. ARST_N low during lane 1 sweep -> all outputs 0 immediately. A new start restarts from lane 0.
